xintf_write_scheduler: RTL
==========================

Name: xintf_write_scheduler

Overview:
- Round-robin scheduler that shares the Zynq-to-DSP XINTF write DPBRAM port among NUM_REQ requesters (e.g. parameter-update path, setpoint path, ADC snapshot path).
- Each granted 32-bit word is written as two 16-bit DPBRAM words (low half first).
- After each word is written, the block runs the o_w_valid/i_w_ready notify handshake with the DSP, guarded by a timeout.
- Sits between the core register/ADC logic and the Zynq-to-DSP DPBRAM, beside the DSP handler.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 9, DPBRAM address width
TIMEOUT_CYC, 2000, maximum WAIT_ACK cycles before abandoning the handshake (>= 2)

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-low reset
i_req  in  NUM_REQ  per-requester write request, level; held until o_ack/o_timeout
i_req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester DPBRAM address of low half; requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
i_req_data  in  NUM_REQ*32  per-requester data word; requester k at [k*32 +: 32]
o_ack  out  NUM_REQ  one-cycle completion pulse to the granted requester
o_timeout  out  1  one-cycle pulse when the DSP handshake expires
o_grant_id  out  $clog2(NUM_REQ)  index of the current/last granted requester
o_busy  out  1  high in any state other than IDLE
o_xintf_addr  out  ADDR_WIDTH  DPBRAM address
o_xintf_ce  out  1  DPBRAM chip enable
o_xintf_we  out  1  DPBRAM write enable
o_xintf_din  out  16  DPBRAM write data
o_w_valid  out  1  write-valid to DSP
i_w_ready  in  1  write-ready from DSP, level

Behaviour:
- All outputs are registered.
- Reset (async, i_rst=0) clears all outputs to 0, sets state=IDLE, rr pointer=0, timeout counter=0. Reset mid-transfer drops ce/we/o_w_valid immediately; the aborted transfer is not acked.
- States: IDLE, WR_LO, WR_HI, WAIT_ACK.
- IDLE:
  - If any i_req bit is set, choose the first set bit scanning from the rr pointer upward with wrap.
  - Latch that requester's addr/data, set o_grant_id, set rr pointer = winner+1 mod NUM_REQ, go to WR_LO.
  - Otherwise stay in IDLE; ce=we=0.
- WR_LO (1 cycle): ce=we=1, addr=latched addr, din=data[15:0].
- WR_HI (1 cycle): ce=we=1, addr=latched addr+1 (modulo 2^ADDR_WIDTH, so 0x1FF wraps to 0x000), din=data[31:16]. Go to WAIT_ACK.
- WAIT_ACK:
  - ce=we=0, o_w_valid=1, timeout counter increments each cycle.
  - i_w_ready sampled high: next cycle o_w_valid=0, o_ack[grant]=1 for 1 cycle, counter=0, go to IDLE.
  - i_w_ready already high on entry: completes on the first WAIT_ACK cycle.
  - Counter reaches TIMEOUT_CYC-1 without ready: o_w_valid=0, o_timeout=1 for 1 cycle, no o_ack, go to IDLE. The requester keeps its request and is re-arbitrated, after other pending requesters because the pointer has already advanced.
  - Ready and timeout in the same cycle: ready wins (ack, no timeout).
- Latency: request sampled in IDLE at cycle N → WR_LO N+1, WR_HI N+2, o_w_valid high N+3; with ready high, o_ack at N+4. IDLE always lasts ≥1 cycle between transfers (5-cycle minimum per word).
- Address/data are captured at grant. Later changes to i_req_addr/i_req_data, or deassertion of i_req mid-transfer, do not affect the transfer; the ack is still issued.
- A requester that holds i_req after its o_ack is treated as a new request. Requesters must drop i_req in the cycle after o_ack to avoid a duplicate write.
- o_busy = (state != IDLE).
- o_grant_id holds its value through IDLE.

Test Plan:
- Single word: reset, req[0]=1, addr0=0x010, data0=0xA5A5_1234, i_w_ready tied 1 → writes 0x1234@0x010, then 0xA5A5@0x011; o_w_valid 1 cycle; o_ack[0] at N+4.
- Round-robin: all four requests held continuously with ready=1 → grant order 0,1,2,3,0; each grant 5 cycles apart; each o_ack goes to the matching requester.
- Address wrap: addr=0x1FF, data=0x0000_BEEF → 0xBEEF@0x1FF, 0x0000@0x000.
- Handshake delay: i_w_ready held low 10 cycles after o_w_valid rises, then high → o_w_valid stays high 11 cycles, ack follows, no timeout.
- Timeout: TIMEOUT_CYC=8, i_w_ready=0 with req[1]=1 → o_w_valid high 8 cycles, o_timeout pulse, no o_ack; with req[2] also pending, req[2] is served before req[1] is retried.
- Async reset asserted in WR_HI: ce/we/o_w_valid go 0 immediately, no ack; after release, rr pointer=0 and the pending req[0] is re-granted.

Source files
------------

// File: rtl/xintf_write_scheduler.sv
// -----------------------------------------------------------------------------
// xintf_write_scheduler
//
// Round-robin scheduler sharing the Zynq-to-DSP XINTF write DPBRAM port among
// NUM_REQ requesters. Each granted 32-bit word is written as two consecutive
// 16-bit DPBRAM words (low half at addr, high half at addr+1), after which the
// o_w_valid / i_w_ready notify handshake with the DSP is run, bounded by
// TIMEOUT_CYC cycles.
//
// Ports:
//   i_clk          system clock
//   i_rst          asynchronous, active-low reset
//   i_req          per-requester level request, held until o_ack / o_timeout
//   i_req_addr     per-requester low-half DPBRAM address (k at [k*ADDR_WIDTH +: ADDR_WIDTH])
//   i_req_data     per-requester 32-bit data word (k at [k*32 +: 32])
//   o_ack          one-cycle completion pulse to the granted requester
//   o_timeout      one-cycle pulse when the DSP handshake expires
//   o_grant_id     index of the current / last granted requester
//   o_busy         high whenever the scheduler is not idle
//   o_xintf_addr   DPBRAM address
//   o_xintf_ce     DPBRAM chip enable
//   o_xintf_we     DPBRAM write enable
//   o_xintf_din    DPBRAM write data
//   o_w_valid      write-valid notification to the DSP
//   i_w_ready      write-ready level from the DSP
//
// All outputs are registered: the combinational block computes the value each
// output must take in the *next* state, and the register block loads it.
// -----------------------------------------------------------------------------
module xintf_write_scheduler #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADDR_WIDTH  = 9,
    parameter int unsigned TIMEOUT_CYC = 2000
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*32-1:0]         i_req_data,
    output logic [NUM_REQ-1:0]            o_ack,
    output logic                          o_timeout,
    output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
    output logic                          o_busy,
    output logic [ADDR_WIDTH-1:0]         o_xintf_addr,
    output logic                          o_xintf_ce,
    output logic                          o_xintf_we,
    output logic [15:0]                   o_xintf_din,
    output logic                          o_w_valid,
    input  logic                          i_w_ready
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned CW  = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE,
        WR_LO,
        WR_HI,
        WAIT_ACK
    } state_t;

    // ---------------------------------------------------------------- state
    state_t                  state_q,    state_d;
    logic [IDW-1:0]          rr_q,       rr_d;
    logic [IDW-1:0]          grant_q,    grant_d;
    logic [ADDR_WIDTH-1:0]   addr_lat_q, addr_lat_d;
    logic [31:0]             data_lat_q, data_lat_d;
    logic [CW-1:0]           cnt_q,      cnt_d;

    // ------------------------------------------------------ output registers
    logic [NUM_REQ-1:0]      ack_q,      ack_d;
    logic                    tmo_q,      tmo_d;
    logic                    busy_q,     busy_d;
    logic [ADDR_WIDTH-1:0]   xaddr_q,    xaddr_d;
    logic                    ce_q,       ce_d;
    logic                    we_q,       we_d;
    logic [15:0]             din_q,      din_d;
    logic                    wvalid_q,   wvalid_d;

    // ------------------------------------------------------------ arbitration
    // First set request bit scanning upward from the round-robin pointer,
    // wrapping at NUM_REQ (which need not be a power of two).
    logic                    found;
    logic [IDW-1:0]          winner;
    logic [IDW-1:0]          idx;
    logic [IDW-1:0]          rr_next;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = IDW'((32'(rr_q) + i) % NUM_REQ);
            if (!found && i_req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign rr_next = IDW'((32'(winner) + 32'd1) % NUM_REQ);

    // -------------------------------------------------- next-state / outputs
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        grant_d    = grant_q;
        addr_lat_d = addr_lat_q;
        data_lat_d = data_lat_q;
        cnt_d      = cnt_q;

        ack_d      = '0;
        tmo_d      = 1'b0;
        xaddr_d    = xaddr_q;
        ce_d       = 1'b0;
        we_d       = 1'b0;
        din_d      = din_q;
        wvalid_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    // Address/data captured here so later input changes or
                    // an early request drop cannot corrupt the transfer.
                    addr_lat_d = i_req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
                    data_lat_d = i_req_data[winner*32 +: 32];
                    grant_d    = winner;
                    rr_d       = rr_next;
                    state_d    = WR_LO;
                    ce_d       = 1'b1;
                    we_d       = 1'b1;
                    xaddr_d    = i_req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
                    din_d      = i_req_data[winner*32 +: 16];
                end
            end

            WR_LO: begin
                // High half goes to the next address, wrapping modulo 2^ADDR_WIDTH.
                state_d = WR_HI;
                ce_d    = 1'b1;
                we_d    = 1'b1;
                xaddr_d = addr_lat_q + ADDR_WIDTH'(1);
                din_d   = data_lat_q[31:16];
            end

            WR_HI: begin
                state_d  = WAIT_ACK;
                wvalid_d = 1'b1;
                cnt_d    = '0;
            end

            WAIT_ACK: begin
                // Ready is checked before the timeout so a ready arriving on
                // the last permitted cycle still completes with an ack.
                if (i_w_ready) begin
                    state_d        = IDLE;
                    ack_d[grant_q] = 1'b1;
                    cnt_d          = '0;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    state_d = IDLE;
                    tmo_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d    = cnt_q + CW'(1);
                    wvalid_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // -------------------------------------------------------------- registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            grant_q    <= '0;
            addr_lat_q <= '0;
            data_lat_q <= '0;
            cnt_q      <= '0;
            ack_q      <= '0;
            tmo_q      <= 1'b0;
            busy_q     <= 1'b0;
            xaddr_q    <= '0;
            ce_q       <= 1'b0;
            we_q       <= 1'b0;
            din_q      <= '0;
            wvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            grant_q    <= grant_d;
            addr_lat_q <= addr_lat_d;
            data_lat_q <= data_lat_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            tmo_q      <= tmo_d;
            busy_q     <= busy_d;
            xaddr_q    <= xaddr_d;
            ce_q       <= ce_d;
            we_q       <= we_d;
            din_q      <= din_d;
            wvalid_q   <= wvalid_d;
        end
    end

    assign o_ack        = ack_q;
    assign o_timeout    = tmo_q;
    assign o_grant_id   = grant_q;
    assign o_busy       = busy_q;
    assign o_xintf_addr = xaddr_q;
    assign o_xintf_ce   = ce_q;
    assign o_xintf_we   = we_q;
    assign o_xintf_din  = din_q;
    assign o_w_valid    = wvalid_q;

endmodule
